// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Two-requester round-robin front end for a single 8N1 UART transmitter.
// One byte is accepted at a time in IDLE. It is framed as a start bit, eight
// data bits sent LSB first, and a stop bit. The bit timing comes entirely from
// an external baud_tick pulse. The tx line is driven straight from a register,
// so it can only change on a clock edge that follows a baud tick.

module uart_tx_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       tx,
  output logic       busy,
  output logic       grant_id,
  output logic       done
);

  // WAIT lines the start bit up to a whole tick period. A tick that lands in
  // the accept cycle does not begin the frame.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    START = 3'd2,
    DATA  = 3'd3,
    STOP  = 3'd4
  } state_e;

  state_e     state_q;
  logic       last_q;
  logic       grant_q;
  logic [2:0] bitIdx_q;
  logic [7:0] shiftReg_q;
  logic       tx_q;
  logic       done_q;

  logic       win0_d;
  logic       win1_d;
  logic       acceptEn_d;
  logic [7:0] winData_d;
  logic [2:0] bitIdxNext_d;

  // Round-robin winner. When both requesters are valid, the one that did not
  // own the previous frame wins. When only one is valid, it wins.
  always_comb begin
    win0_d = 1'b0;
    win1_d = 1'b0;
    if (req0_valid && req1_valid) begin
      win0_d = last_q;
      win1_d = ~last_q;
    end else begin
      win0_d = req0_valid;
      win1_d = req1_valid;
    end
  end

  // Accepting is allowed only in a settled IDLE cycle. The cycle that shows
  // the done pulse is kept out, so a new frame always starts on the cycle
  // after done. A reset cycle never hands out a ready.
  always_comb begin
    acceptEn_d   = (state_q == IDLE) && !done_q && !rst;
    winData_d    = win1_d ? req1_data : req0_data;
    bitIdxNext_d = bitIdx_q + 3'd1;
  end

  assign req0_ready = acceptEn_d & win0_d;
  assign req1_ready = acceptEn_d & win1_d;

  // Frame sequencer. It owns every register: state, arbitration history, the
  // shift register and the registered tx/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      grant_q    <= 1'b0;
      bitIdx_q   <= 3'd0;
      shiftReg_q <= 8'h00;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (req0_ready || req1_ready) begin
            shiftReg_q <= winData_d;
            grant_q    <= win1_d;
            last_q     <= win1_d;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (baud_tick) begin
            state_q <= START;
            tx_q    <= 1'b0;
          end
        end
        START: begin
          if (baud_tick) begin
            state_q  <= DATA;
            bitIdx_q <= 3'd0;
            tx_q     <= shiftReg_q[0];
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end else begin
              bitIdx_q <= bitIdxNext_d;
              tx_q     <= shiftReg_q[bitIdxNext_d];
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            tx_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;
  assign done     = done_q;

endmodule
